// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
//
// Purpose:
//   General-purpose event/timebase counter. Counts over 0..MOD_MAX in either
//   direction, with synchronous clear and load, and wraps or saturates at the
//   boundary. Each boundary step raises a registered one-cycle terminal-count
//   pulse and sets a sticky overflow flag.
//
// Parameters:
//   WIDTH    - counter width in bits (2..32)
//   MOD_MAX  - highest count value, must fit in WIDTH bits
//   SATURATE - 0: wrap at the boundary, 1: hold at the boundary
//   PRESCALE - enabled cycles per count step (prescaler build only, >= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   enable     in   count enable
//   clear      in   synchronous clear to 0, highest synchronous priority
//   load       in   synchronous load of load_value
//   load_value in   value to load, clamped to MOD_MAX
//   up_down    in   1 = count up, 0 = count down
//   out        out  current count, registered
//   tc         out  terminal-count pulse, registered, one cycle wide
//   overflow   out  sticky boundary-crossing flag
//
// Configuration macro:
//   COUNTER_PRESCALER_EN - when defined, an internal prescaler gates the count
//   steps so that one step happens every PRESCALE enabled cycles. When left
//   undefined no prescaler logic exists and every enabled cycle is a step.
// ---------------------------------------------------------------------------
module param_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = 255,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             overflow
);

  // Elaboration-time sanity checks on the configuration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_counter: WIDTH must be in 2..32");
  end
  if (64'(MOD_MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_mod_max
    $error("param_counter: MOD_MAX does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             step;
  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] load_clamped;

  // A step is only possible when neither clear nor load claims the edge.
  logic             step_req;
  assign step_req = enable && !clear && !load;

`ifdef COUNTER_PRESCALER_EN
  // Prescaler counts 0..PRESCALE-1 on each step request; the counter only
  // advances on the request that finds it at its last value. With
  // PRESCALE=1 the prescaler sits at 0, which is always its last value.
  localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            ps_last;

  assign ps_last = (ps_q == PS_LAST);

  always_comb begin
    ps_d = ps_q;
    if (clear || load) begin
      ps_d = '0;
    end else if (enable) begin
      ps_d = ps_last ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign step = step_req && ps_last;
`else
  assign step = step_req;
`endif

  // Boundary detection uses >= / == at WIDTH bits so no increment is ever
  // evaluated at the top of the range, keeping MOD_MAX = 2^WIDTH-1 safe.
  assign at_top       = (cnt_q >= MAX_V);
  assign at_bottom    = (cnt_q == '0);
  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

  // Next-state for count, terminal-count pulse and sticky overflow.
  // tc defaults low so it is a one-cycle pulse per boundary step.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (up_down) begin
        if (at_top) begin
          cnt_d = SATURATE ? MAX_V : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (at_bottom) begin
          cnt_d = SATURATE ? '0 : MAX_V;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out      = cnt_q;
  assign tc       = tc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Testbench for param_counter. Three instances share clock and reset:
//   0: WIDTH=8, MOD_MAX=9,   wrap
//   1: WIDTH=8, MOD_MAX=9,   saturate
//   2: WIDTH=8, MOD_MAX=255, wrap (full-range boundary)
module tb_param_counter;

   typedef struct {
      int         sel;
      logic       clr;
      logic       ld;
      logic       en;
      logic       ud;
      logic [7:0] lv;
      logic [7:0] eo;
      logic       etc;
      logic       eov;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr_s [3];
   logic       ld_s  [3];
   logic       en_s  [3];
   logic       ud_s  [3];
   logic [7:0] lv_s  [3];
   logic [7:0] out_s [3];
   logic       tc_s  [3];
   logic       ov_s  [3];

   vec_t exp_q [$];
   vec_t tbl   [$];
   int   nVec  = 0;
   int   nFail = 0;

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   param_counter #(.WIDTH(8), .MOD_MAX(9), .SATURATE(1'b0), .PRESCALE(4)) dut_wrap (
      .clk(clk), .reset(reset), .enable(en_s[0]), .clear(clr_s[0]), .load(ld_s[0]),
      .load_value(lv_s[0]), .up_down(ud_s[0]), .out(out_s[0]), .tc(tc_s[0]), .overflow(ov_s[0]));

   param_counter #(.WIDTH(8), .MOD_MAX(9), .SATURATE(1'b1), .PRESCALE(4)) dut_sat (
      .clk(clk), .reset(reset), .enable(en_s[1]), .clear(clr_s[1]), .load(ld_s[1]),
      .load_value(lv_s[1]), .up_down(ud_s[1]), .out(out_s[1]), .tc(tc_s[1]), .overflow(ov_s[1]));

   param_counter #(.WIDTH(8), .MOD_MAX(255), .SATURATE(1'b0), .PRESCALE(4)) dut_full (
      .clk(clk), .reset(reset), .enable(en_s[2]), .clear(clr_s[2]), .load(ld_s[2]),
      .load_value(lv_s[2]), .up_down(ud_s[2]), .out(out_s[2]), .tc(tc_s[2]), .overflow(ov_s[2]));

   // Builds one vector record: inputs for instance sel plus its expected outputs.
   function automatic vec_t mk(input int sel, input logic clr, input logic ld, input logic en,
                               input logic ud, input logic [7:0] lv, input logic [7:0] eo,
                               input logic etc, input logic eov, input string name);
      vec_t v;
      v.sel = sel; v.clr = clr; v.ld = ld; v.en = en; v.ud = ud; v.lv = lv;
      v.eo = eo; v.etc = etc; v.eov = eov; v.name = name;
      return v;
   endfunction

   // Parks every instance in hold (no clear, load or enable).
   task automatic idleAll();
      for (int i = 0; i < 3; i++) begin
         clr_s[i] = 1'b0; ld_s[i] = 1'b0; en_s[i] = 1'b0; ud_s[i] = 1'b1; lv_s[i] = 8'd0;
      end
   endtask

   // Pops the oldest expectation and compares it with the addressed instance.
   task automatic checkOutput();
      vec_t e;
      if (exp_q.size() == 0) begin
         nVec++;
         nFail++;
         $display("[TB] FAIL scoreboard_empty: no expectation queued, required one");
         return;
      end
      e = exp_q.pop_front();
      nVec++;
      if (out_s[e.sel] !== e.eo || tc_s[e.sel] !== e.etc || ov_s[e.sel] !== e.eov) begin
         nFail++;
         $display("[TB] FAIL %s (dut%0d): got out=%0d tc=%b ovf=%b, expected out=%0d tc=%b ovf=%b",
                  e.name, e.sel, out_s[e.sel], tc_s[e.sel], ov_s[e.sel], e.eo, e.etc, e.eov);
      end
   endtask

   // Drives one vector away from the edge, queues its expectation and checks
   // it just after the rising edge that consumes it.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      idleAll();
      clr_s[v.sel] = v.clr;
      ld_s[v.sel]  = v.ld;
      en_s[v.sel]  = v.en;
      ud_s[v.sel]  = v.ud;
      lv_s[v.sel]  = v.lv;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Checks the present outputs with no clock edge involved.
   task automatic expectNow(input vec_t v);
      exp_q.push_back(v);
      checkOutput();
   endtask

   // Hard bound on total run time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idleAll();
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) expectNow(mk(i, 0, 0, 0, 1, 0, 8'd0, 0, 0, "reset_state"));
      @(negedge clk);
      reset = 1'b1;

`ifdef COUNTER_PRESCALER_EN
      // One step every four enabled cycles from reset.
      for (int k = 1; k <= 16; k++)
         applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'(k / 4), 0, 0, "prescale_run"));
      // Two enabled cycles, a two-cycle gap, then the delayed step.
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd4, 0, 0, "prescale_pre1"));
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd4, 0, 0, "prescale_pre2"));
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 8'd4, 0, 0, "prescale_gap1"));
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 8'd4, 0, 0, "prescale_gap2"));
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd4, 0, 0, "prescale_pre3"));
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd5, 0, 0, "prescale_late_step"));
      // Load zeroes the prescaler: four more enabled cycles for the next step.
      applyStimulus(mk(0, 0, 1, 1, 1, 8'd2, 8'd2, 0, 0, "prescale_load"));
      for (int k = 1; k <= 3; k++)
         applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd2, 0, 0, "prescale_after_load"));
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'd3, 0, 0, "prescale_step_after_load"));
`else
      // Wrap instance: count 1..9, wrap to 0 with tc, continue.
      for (int k = 1; k <= 12; k++)
         tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'(k % 10), (k == 10), (k >= 10), "wrap_up"));
      tbl.push_back(mk(0, 1, 0, 1, 1, 0,   8'd0, 0, 0, "clear"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,   8'd9, 1, 1, "down_wrap"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,   8'd8, 0, 1, "down_step"));
      tbl.push_back(mk(0, 0, 1, 1, 1, 200, 8'd9, 0, 1, "load_clamp"));
      tbl.push_back(mk(0, 1, 1, 1, 1, 200, 8'd0, 0, 0, "clear_over_load"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 5,   8'd5, 0, 0, "load_no_enable"));
      tbl.push_back(mk(0, 0, 1, 0, 1, 4,   8'd4, 0, 0, "load_4"));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0,   8'd5, 0, 0, "toggle_up"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,   8'd4, 0, 0, "toggle_down"));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0,   8'd5, 0, 0, "toggle_up"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,   8'd4, 0, 0, "toggle_down"));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   8'd4, 0, 0, "hold"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   8'd4, 0, 0, "hold"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 9,   8'd9, 0, 0, "load_top"));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0,   8'd0, 1, 1, "top_wrap"));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,   8'd0, 0, 1, "tc_drop"));
      // Saturating instance: pinned at 0 going down, tc on every attempt.
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'd0, 1, 1, "sat_low"));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 8'd0, 0, 0, "sat_clear"));
      tbl.push_back(mk(1, 0, 1, 0, 1, 8, 8'd8, 0, 0, "sat_load"));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'd9, 0, 0, "sat_up"));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'd9, 1, 1, "sat_high"));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'd9, 1, 1, "sat_high"));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'd8, 0, 1, "sat_leave"));
      // Full-range instance: MOD_MAX equals the all-ones value.
      tbl.push_back(mk(2, 0, 1, 0, 1, 254, 8'd254, 0, 0, "full_load"));
      tbl.push_back(mk(2, 0, 0, 1, 1, 0,   8'd255, 0, 0, "full_up"));
      tbl.push_back(mk(2, 0, 0, 1, 1, 0,   8'd0,   1, 1, "full_wrap_up"));
      tbl.push_back(mk(2, 0, 0, 1, 0, 0,   8'd255, 1, 1, "full_wrap_down"));
      tbl.push_back(mk(2, 0, 1, 1, 0, 200, 8'd200, 0, 1, "full_load_keeps_ovf"));
      tbl.push_back(mk(2, 0, 0, 1, 1, 0,   8'd201, 0, 1, "full_up_after_load"));

      foreach (tbl[i]) applyStimulus(tbl[i]);

      // Reset in the middle of a count on the wrap instance.
      for (int k = 1; k <= 5; k++)
         applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'(k), 0, 1, "pre_reset_count"));
      #2;
      reset = 1'b0;
      #1;
      expectNow(mk(0, 0, 0, 0, 1, 0, 8'd0, 0, 0, "async_reset"));
      en_s[0] = 1'b1;
      ud_s[0] = 1'b1;
      @(posedge clk);
      #1;
      expectNow(mk(0, 0, 0, 1, 1, 0, 8'd0, 0, 0, "held_in_reset"));
      @(negedge clk);
      en_s[0] = 1'b0;
      reset   = 1'b1;
      for (int k = 1; k <= 3; k++)
         applyStimulus(mk(0, 0, 0, 1, 1, 0, 8'(k), 0, 0, "after_reset"));
`endif

      if (exp_q.size() != 0) begin
         nFail++;
         $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's fixed 8-bit enable counter.
- Configurable width, modulus, up/down direction, synchronous load and clear, wrap or saturate mode.
- Registered terminal-count pulse and sticky overflow flag.
- Used as a general event/timebase counter in datapath and control logic.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MOD_MAX, 255: highest count value; count range is 0..MOD_MAX; must be <= 2^WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundary; 1 = hold at the boundary.
- PRESCALE, 4: enabled cycles per count step; used only with COUNTER_PRESCALER_EN; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  count enable.
- clear  in  1  synchronous clear to 0; highest synchronous priority.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load; clamped to MOD_MAX.
- up_down  in  1  1 = count up, 0 = count down; sampled each cycle.
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, 1 cycle wide.
- overflow  out  1  sticky boundary-crossing flag.

Behaviour:
- Reset (reset=0, async): out=0, tc=0, overflow=0, prescaler=0 immediately. All outputs stay at reset values while reset is low.
- Release of reset is synchronous to clk: the first update occurs on the first rising edge with reset=1.
- Priority per rising edge: clear > load > count step > hold.
- clear=1:
  - out<=0, tc<=0, overflow<=0, prescaler<=0.
  - load and enable are ignored.
- load=1 (clear=0):
  - out<=min(load_value, MOD_MAX), tc<=0, prescaler<=0.
  - overflow is unchanged.
  - load is honoured regardless of enable.
- Step condition: enable=1 and no clear or load in the same cycle. With COUNTER_PRESCALER_EN defined, the prescaler must also be at terminal (see Optional Feature).
- Step, up (up_down=1):
  - If out<MOD_MAX: out<=out+1.
  - If out==MOD_MAX: out<=0 when SATURATE=0, or out holds at MOD_MAX when SATURATE=1. In both modes, tc<=1 and overflow<=1.
- Step, down (up_down=0):
  - If out>0: out<=out-1.
  - If out==0: out<=MOD_MAX when SATURATE=0, or out holds at 0 when SATURATE=1. In both modes, tc<=1 and overflow<=1.
- tc timing:
  - tc is high for exactly one cycle after each boundary step.
  - In any cycle with no boundary step, tc<=0.
  - When saturated and enable stays high, tc pulses on every step that attempts to cross the boundary (it is not a level).
- Direction change: takes effect on the same edge it is sampled; no pipeline or latency.
- Arithmetic: out is never driven outside 0..MOD_MAX. Internal compare is done at WIDTH bits with no intermediate overflow; MOD_MAX=2^WIDTH-1 must work.
- Latency: all inputs to out/tc take 1 clock.
- Reset mid-count: asynchronously forces the reset state. The count restarts from 0 on the first enabled edge after release.

Optional Feature:
- Macro: COUNTER_PRESCALER_EN.
- Defined:
  - Internal prescaler counts 0..PRESCALE-1 on each cycle with enable=1 and no clear or load.
  - A count step occurs only on the edge where the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - enable=0 holds the prescaler.
  - clear, load and reset zero the prescaler.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic is built, PRESCALE is ignored, and every enabled cycle is a step.

Test Plan:
- Setup WIDTH=8, MOD_MAX=9, SATURATE=0. Hold reset low for 5 cycles, release, enable=1, up_down=1 for 12 cycles -> out 0,1,...,9,0,1; tc high exactly 1 cycle when out shows 0 after 9; overflow=1 thereafter.
- SATURATE=1, MOD_MAX=9, up_down=0 from out=0, enable held 3 cycles -> out stays 0; tc pulses on each of the 3 steps; overflow=1. Then clear=1 -> out=0, overflow=0.
- load=1 with load_value=200 (MOD_MAX=9), with clear=0 -> out=9. Same edge with clear=1 and load=1 -> out=0 (clear wins). load with enable=0 -> still loads.
- Count up to 5, assert reset low mid-cycle (between edges) -> out=0, tc=0, overflow=0 immediately. After release, 3 enabled edges -> out=3.
- Toggle up_down every cycle from out=4 with enable=1 -> out 5,4,5,4; no tc. Toggle enable off for 2 cycles -> out holds.
- COUNTER_PRESCALER_EN defined, PRESCALE=4, enable=1 for 16 cycles from reset -> out increments once every 4 cycles, reaching 4. Deassert enable for 2 cycles mid-period -> the step is delayed by exactly 2 cycles.
